// File: rtl/comb_stim_seq.sv
// Stimulus sequencer: sweeps all eight {b3,b2,b1} patterns into comb_complex and packs b4 into resp_o.
// Optional result checker enabled by defining COMB_STIM_SEQ_CHECK_EN.
module comb_stim_seq #(
   parameter int unsigned DWELL  = 4,
   parameter logic [7:0]  EXPECT = 8'hF8
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   output logic       b1_o,
   output logic       b2_o,
   output logic       b3_o,
   input  logic       b4_i,
   output logic       busy_o,
   output logic       done_o,
   output logic [7:0] resp_o,
   output logic       mismatch_o
);

   typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

   localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

   state_t     state;
   logic [2:0] k;
   logic [7:0] cnt;
   logic [2:0] next_k;
   logic [7:0] final_resp;

   assign next_k = k + 3'd1;

   // Includes the sample being taken this cycle, so the last pattern is part of the compare.
   always_comb begin
      final_resp    = resp_o;
      final_resp[k] = b4_i;
   end

`ifdef COMB_STIM_SEQ_CHECK_EN
   logic mismatch_q;
   assign mismatch_o = mismatch_q;
`else
   logic unused_final_resp;
   assign unused_final_resp = ^final_resp ^ ^EXPECT;
   assign mismatch_o = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= IDLE;
         k      <= 3'd0;
         cnt    <= 8'd0;
         b1_o   <= 1'b0;
         b2_o   <= 1'b0;
         b3_o   <= 1'b0;
         busy_o <= 1'b0;
         done_o <= 1'b0;
         resp_o <= 8'h00;
`ifdef COMB_STIM_SEQ_CHECK_EN
         mismatch_q <= 1'b0;
`endif
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  state  <= DRIVE;
                  k      <= 3'd0;
                  cnt    <= 8'd0;
                  {b3_o, b2_o, b1_o} <= 3'd0;
                  busy_o <= 1'b1;
                  resp_o <= 8'h00;
`ifdef COMB_STIM_SEQ_CHECK_EN
                  mismatch_q <= 1'b0;
`endif
               end
            end
            DRIVE: begin
               if (cnt == DWELL_LAST) begin
                  resp_o[k] <= b4_i;
                  cnt       <= 8'd0;
                  if (k == 3'd7) begin
                     state  <= DONE;
                     busy_o <= 1'b0;
                     done_o <= 1'b1;
                     {b3_o, b2_o, b1_o} <= 3'd0;
`ifdef COMB_STIM_SEQ_CHECK_EN
                     mismatch_q <= (final_resp != EXPECT);
`endif
                  end else begin
                     k <= next_k;
                     {b3_o, b2_o, b1_o} <= next_k;
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
